// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;
  localparam int unsigned MEM_ARB_BE_W   = MEM_ARB_DATA_W / 8;

  localparam logic [MEM_ARB_BE_W-1:0] MEM_ARB_BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-side, D-side and downstream memory handshakes.
// master = arbiter view; slave = requesters plus memory around it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [DATA_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic              d_resp;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  i_read, i_address,
    output i_resp, i_rdata,
    input  d_read, d_write, d_address, d_wdata, d_byte_enable,
    output d_resp, d_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    output i_read, i_address,
    input  i_resp, i_rdata,
    output d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  d_resp, d_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Combinational grant decision between the I and D requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  requester_t last_grant,
`endif
  output logic       grant_valid,
  output requester_t grant_id
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_D;
    if (i_req && !d_req) begin
      grant_id = REQ_I;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    else if (i_req && d_req && (last_grant == REQ_D)) begin
      grant_id = REQ_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties instead of D priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = '1;

  arb_state_t        state;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;

  logic       i_req;
  logic       d_req;
  logic       grant_valid;
  requester_t grant_id;

  // A simultaneous d_read/d_write is treated as a write.
  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  requester_t last_grant;
`endif

  mem_arb_select u_select (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grant state plus captured downstream request, held for the whole grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= BE_ALL;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant    <= REQ_D;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (grant_id == REQ_D) begin
              state         <= GRANT_D;
              mem_write_q   <= bus.d_write;
              mem_read_q    <= ~bus.d_write;
              mem_address_q <= bus.d_address;
              mem_wdata_q   <= bus.d_write ? bus.d_wdata : '0;
              mem_be_q      <= bus.d_write ? bus.d_byte_enable : BE_ALL;
            end else begin
              state         <= GRANT_I;
              mem_write_q   <= 1'b0;
              mem_read_q    <= 1'b1;
              mem_address_q <= bus.i_address;
              mem_wdata_q   <= '0;
              mem_be_q      <= BE_ALL;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= grant_id;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          // Leaving the grant drops the request so it is never re-issued back to back.
          if (bus.mem_resp) begin
            state         <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= BE_ALL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;

  // Completion goes only to the granted side; read data is a plain passthrough.
  assign bus.i_resp  = bus.mem_resp & (state == GRANT_I);
  assign bus.d_resp  = bus.mem_resp & (state == GRANT_D);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule
